rom_share_arbiter: RTL and testbench
====================================

ROM_SHARE_ARBITER -- requirements
Module: rom_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the encrypted-data ROM, range 2..8.
REQ-002 Parameter ADDR_W, default 5: ROM address width (32 entries).
REQ-003 Parameter DATA_W, default 8: ROM data width.
REQ-004 Parameter ROM_LAT, default 1: cycles from rom_address change to valid rom_q, range 1..3.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  NUM_REQ  per-requester read request, level.
REQ-008 req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
REQ-009 gnt  out  NUM_REQ  one-hot, registered; one-cycle pulse meaning the address was issued.
REQ-010 rom_address  out  ADDR_W  registered address to the ROM.
REQ-011 rom_q  in  DATA_W  ROM read data.
REQ-012 rvalid  out  NUM_REQ  one-hot, one-cycle pulse marking rdata for requester i.
REQ-013 rdata  out  DATA_W  shared read-data bus, equal to rom_q while any rvalid is high.
REQ-014 busy  out  1  high while any issued read has not yet returned.

Function
REQ-015 Arbitration each cycle over eligible requesters: req[i]=1 and gnt[i]=0 in that cycle.
REQ-016 Requester i holds req[i] and its address stable until it sees gnt[i]; req[i] still high in the gnt cycle is ignored; req[i] high in the following cycle is a new request.
REQ-017 At most one grant per cycle; issue rate up to one read per cycle to different requesters.
REQ-018 Winner w chosen at edge t: at t+1 gnt[w]=1 and rom_address = req_addr slice w.
REQ-019 Round-robin: search starts at index last_winner+1 modulo NUM_REQ; last_winner updates only on a grant.
REQ-020 No eligible requester: gnt=0, rom_address and last_winner hold.
REQ-021 Return pipeline: ROM_LAT-deep shift register of {valid, winner index}; rvalid[w]=1 exactly ROM_LAT cycles after gnt[w], with rdata=rom_q in that cycle.
REQ-022 Back-to-back grants to different requesters return in issue order, one per cycle, with no loss.
REQ-023 rdata holds its last value when no rvalid is high.
REQ-024 busy = OR of the pipeline valid bits; it is 0 when the pipeline is empty.
REQ-025 Simultaneous request from all NUM_REQ requesters: each is served exactly once within NUM_REQ consecutive grant cycles.
REQ-026 last_winner wraps from NUM_REQ-1 to 0.

Reset
REQ-027 While reset=1: gnt=0, rvalid=0, rom_address=0, rdata=0, busy=0, pipeline valids cleared, last_winner=NUM_REQ-1, so requester 0 has first priority.
REQ-028 Reset asserted mid-operation discards in-flight reads; no rvalid appears for them after reset deasserts.
REQ-029 First grant is possible at the first rising edge after reset deasserts.

Configuration
REQ-030 Macro ROM_SHARE_FIXED_PRIO_EN defined: fixed priority, lowest eligible index wins; last_winner is unused.
REQ-031 Macro ROM_SHARE_FIXED_PRIO_EN undefined: round-robin per REQ-019; all other behaviour is identical.

Verification (NUM_REQ=4, ROM_LAT=1, ROM[a]=a XOR 8'hA5)
REQ-032 After reset, req=4'b0001, addr0=5'd3 -> gnt=0001 next cycle, rom_address=3; one cycle later rvalid=0001, rdata=8'hA6; busy high for exactly 1 cycle.
REQ-033 req=4'b1111, addrs 0..3 = 1,2,3,4 held per REQ-016 -> gnt order 0001,0010,0100,1000 on consecutive cycles; rdata sequence A4,A7,A6,A1.
REQ-034 req0 and req2 continuously re-requesting (rising again the cycle after each gnt) -> grants alternate 0,2,0,2 and neither is starved.
REQ-035 Reset pulsed in the cycle after gnt=0010 -> no rvalid for requester 1; outputs at reset values; the next grant goes to requester 0 if it is requesting.
REQ-036 ROM_SHARE_FIXED_PRIO_EN defined, req=4'b0110 held continuously (re-requesting) -> requester 1 granted every other cycle; requester 2 granted only in the gaps when gnt[1] is high.

Source files
------------

// File: rtl/rom_share_arbiter.sv
// Shares one encrypted-data ROM among NUM_REQ requesters: one address issued per cycle, read data
// returned in issue order ROM_LAT cycles later. Define ROM_SHARE_FIXED_PRIO_EN for fixed priority.
module rom_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_q;
    logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic               grant_d;
    logic [NUM_REQ-1:0] elig;
    logic               pipe_vld_q [ROM_LAT];
    logic [IDX_W-1:0]   pipe_idx_q [ROM_LAT];
    logic [DATA_W-1:0]  rdata_q;
    logic               rvalid_any;

    // A requester that is being granted this cycle is not eligible again until next cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        elig    = req & ~gnt_q;
        grant_d = 1'b0;
        win_d   = win_q;
`ifdef ROM_SHARE_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                grant_d = 1'b1;
                win_d   = IDX_W'(i);
            end
        end
`else
        // Walk from farthest to nearest offset so the candidate right after win_q wins last.
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (elig[(int'(win_q) + off) % NUM_REQ]) begin
                grant_d = 1'b1;
                win_d   = IDX_W'((int'(win_q) + off) % NUM_REQ);
            end
        end
`endif
        rom_address_d = grant_d ? req_addr[int'(win_d)*ADDR_W +: ADDR_W] : rom_address_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q         <= '0;
            rom_address_q <= '0;
            win_q         <= IDX_W'(NUM_REQ - 1);
        end else begin
            gnt_q         <= grant_d ? (NUM_REQ'(1) << win_d) : '0;
            rom_address_q <= rom_address_d;
            win_q         <= win_d;
        end
    end

    // Return pipeline tracks which requester owns each read in flight; win_q equals the issued index while gnt_q is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the pipeline valids must be reset so in-flight reads are dropped; the indices only for tidiness.
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_idx_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= |gnt_q;
            pipe_idx_q[0] <= win_q;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_idx_q[k] <= pipe_idx_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata;
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < ROM_LAT; k++) busy = busy | pipe_vld_q[k];
    end

    assign rvalid_any  = pipe_vld_q[ROM_LAT-1];
    assign rvalid      = rvalid_any ? (NUM_REQ'(1) << pipe_idx_q[ROM_LAT-1]) : '0;
    assign rdata       = rvalid_any ? rom_q : rdata_q;
    assign gnt         = gnt_q;
    assign rom_address = rom_address_q;

endmodule

// File: tb/tb_rom_share_arbiter.sv
// Directed bench for rom_share_arbiter with a one-cycle-latency ROM model holding ROM[a] = a ^ 8'hA5.
module tb_rom_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q = '0;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    int n_tests = 0;
    int n_fail  = 0;

    rom_share_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rom_address(rom_address), .rom_q(rom_q), .rvalid(rvalid), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_q <= DATA_W'(rom_address) ^ 8'hA5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0] exp_gnt [6];
    logic [3:0] exp_rv  [6];
    logic [7:0] exp_rd  [6];

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_addr", 32'(rom_address), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single read from requester 0 at address 3.
        req      = 4'b0001;
        req_addr = {5'd0, 5'd0, 5'd0, 5'd3};
        step();
        check("s_gnt", 32'(gnt), 32'h1);
        check("s_addr", 32'(rom_address), 32'd3);
        check("s_busy0", 32'(busy), 32'h0);
        req = '0;
        step();
        check("s_gnt_off", 32'(gnt), 32'h0);
        check("s_rvalid", 32'(rvalid), 32'h1);
        check("s_rdata", 32'(rdata), 32'hA6);
        check("s_busy1", 32'(busy), 32'h1);
        step();
        check("s_rvalid_off", 32'(rvalid), 32'h0);
        check("s_busy_off", 32'(busy), 32'h0);
        check("s_rdata_hold", 32'(rdata), 32'hA6);
        check("s_addr_hold", 32'(rom_address), 32'd3);

        // All four requesting at once; each drops its request on seeing its grant.
        do_reset();
        req      = 4'b1111;
        req_addr = {5'd4, 5'd3, 5'd2, 5'd1};
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        exp_rv  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        exp_rd  = '{8'h00,   8'hA4,   8'hA7,   8'hA6,   8'hA1,   8'hA1};
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("all_gnt%0d", c), 32'(gnt), 32'(exp_gnt[c]));
            check($sformatf("all_rv%0d", c), 32'(rvalid), 32'(exp_rv[c]));
            check($sformatf("all_rd%0d", c), 32'(rdata), 32'(exp_rd[c]));
            check($sformatf("all_busy%0d", c), 32'(busy), 32'(exp_rv[c] != 4'b0000));
            req = req & ~gnt;
        end
        check("all_addr_hold", 32'(rom_address), 32'd4);

        // Requesters 0 and 2 hold req continuously: strict alternation, wrap from last winner 3.
        req      = 4'b0101;
        req_addr = {5'd0, 5'd9, 5'd0, 5'd7};
        exp_gnt = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
        exp_rv  = '{4'b0000, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
        exp_rd  = '{8'hA1,   8'hA2,   8'hAC,   8'hA2,   8'hAC,   8'hA2};
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("alt_gnt%0d", c), 32'(gnt), 32'(exp_gnt[c]));
            check($sformatf("alt_addr%0d", c), 32'(rom_address), (c % 2 == 0) ? 32'd7 : 32'd9);
            check($sformatf("alt_rv%0d", c), 32'(rvalid), 32'(exp_rv[c]));
            check($sformatf("alt_rd%0d", c), 32'(rdata), 32'(exp_rd[c]));
        end
        req = '0;
        step();
        step();

        // Reset lands while requester 1's read is in flight: it must never return.
        do_reset();
        req      = 4'b0011;
        req_addr = {5'd0, 5'd0, 5'd6, 5'd5};
        step();
        check("rr_gnt0", 32'(gnt), 32'h1);
        req = req & ~gnt;
        step();
        check("rr_gnt1", 32'(gnt), 32'h2);
        check("rr_addr1", 32'(rom_address), 32'd6);
        req   = 4'b0001;
        reset = 1'b1;
        #1;
        check("rr_rst_gnt", 32'(gnt), 32'h0);
        check("rr_rst_addr", 32'(rom_address), 32'h0);
        check("rr_rst_rdata", 32'(rdata), 32'h0);
        step();
        check("rr_rst_rvalid", 32'(rvalid), 32'h0);
        check("rr_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rr_after_gnt", 32'(gnt), 32'h1);
        check("rr_after_rvalid", 32'(rvalid), 32'h0);
        check("rr_after_addr", 32'(rom_address), 32'd5);
        req = '0;
        step();
        check("rr_ret_rvalid", 32'(rvalid), 32'h1);
        check("rr_ret_rdata", 32'(rdata), 32'hA0);

        // Requesters 1 and 2 held continuously: 1 and 2 alternate in either arbitration mode.
        do_reset();
        req      = 4'b0110;
        req_addr = {5'd0, 5'd2, 5'd1, 5'd0};
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("p12_gnt%0d", c), 32'(gnt), (c % 2 == 0) ? 32'h2 : 32'h4);
        end
        req = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
